// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int NUM_CH         = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int MIN_DWELL_SYNC = 3;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control, mux-side and frame-report signals of the scan sequencer.
interface mux_scan_ctrl_if #(
  parameter int DWELL_W = 8,
  parameter int FCNT_W  = 8
);

  logic               start;
  logic               stop;
  logic               cont;
  logic [DWELL_W-1:0] dwell;
  logic               m;
  logic               c0;
  logic               c1;
  logic               busy;
  logic [3:0]         frame;
  logic               frame_valid;
  logic [FCNT_W-1:0]  frame_cnt;

  modport master (
    output start, stop, cont, dwell, m,
    input  c0, c1, busy, frame, frame_valid, frame_cnt
  );

  modport slave (
    input  start, stop, cont, dwell, m,
    output c0, c1, busy, frame, frame_valid, frame_cnt
  );

endinterface

// File: rtl/mux_scan_sync.sv
// Multi-flop synchroniser for the scanned mux output, async active-low reset to 0.
module mux_scan_sync
  import mux_scan_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer driving the 4:1 mux selects and packing sampled outputs into frames.
// Build option: define MUX_SCAN_SYNC_EN to synchronise m and raise the minimum dwell to 3.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int FCNT_W  = 8
) (
  input logic            clk,
  input logic            rst_n,
  mux_scan_ctrl_if.slave bus
);

`ifdef MUX_SCAN_SYNC_EN
  // Sampling waits out the synchroniser latency, so each channel needs at least 3 cycles.
  localparam int MIN_DWELL = MIN_DWELL_SYNC;
  logic m_s;

  mux_scan_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.m),
    .q     (m_s)
  );
`else
  localparam int MIN_DWELL = 1;
  logic m_s;

  assign m_s = bus.m;
`endif

  localparam logic [DWELL_W-1:0] MIN_D = DWELL_W'(MIN_DWELL);

  scan_state_t         state;
  scan_state_t         next_state;
  logic [1:0]          ch;
  logic [DWELL_W-1:0]  cnt;
  logic [DWELL_W-1:0]  d_lat;
  logic                cont_lat;
  logic [NUM_CH-2:0]   shadow;
  logic [3:0]          frame_q;
  logic [FCNT_W-1:0]   fcnt_q;
  logic                last_tick;

  assign last_tick = (cnt == d_lat - DWELL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // stop outranks everything; DONE lasts exactly one cycle
  always_comb begin
    next_state      = state;
    bus.busy        = 1'b0;
    bus.frame_valid = 1'b0;
    {bus.c1, bus.c0} = 2'b00;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) next_state = SCAN;
      end
      SCAN: begin
        bus.busy         = 1'b1;
        {bus.c1, bus.c0} = ch;
        if (bus.stop)                       next_state = IDLE;
        else if (last_tick && ch == 2'd3)   next_state = DONE;
      end
      DONE: begin
        bus.busy        = 1'b1;
        bus.frame_valid = 1'b1;
        if (bus.stop)       next_state = IDLE;
        else if (cont_lat)  next_state = SCAN;
        else                next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The last channel's sample goes straight into the frame so it is visible in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch       <= 2'd0;
      cnt      <= '0;
      d_lat    <= '0;
      cont_lat <= 1'b0;
      shadow   <= '0;
      frame_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            ch       <= 2'd0;
            cnt      <= '0;
            d_lat    <= (bus.dwell < MIN_D) ? MIN_D : bus.dwell;
            cont_lat <= bus.cont;
          end
        end
        SCAN: begin
          if (!bus.stop) begin
            if (last_tick) begin
              cnt <= '0;
              if (ch == 2'd3) begin
                frame_q <= {m_s, shadow};
                fcnt_q  <= fcnt_q + FCNT_W'(1);
              end else begin
                shadow[ch] <= m_s;
                ch         <= ch + 2'd1;
              end
            end else begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
        end
        DONE: begin
          ch  <= 2'd0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.frame     = frame_q;
  assign bus.frame_cnt = fcnt_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: vector table, scoreboarded frame reports, corner sequences.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int DWELL_W = 8;
  localparam int FCNT_W  = 8;
`ifdef MUX_SCAN_SYNC_EN
  localparam int MIN_D = MIN_DWELL_SYNC;
`else
  localparam int MIN_D = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] x = 4'b0000;
  logic [1:0] sel;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_scan_ctrl_if #(.DWELL_W(DWELL_W), .FCNT_W(FCNT_W)) bus ();

  // Behavioural 4:1 mux closing the loop around the sequencer
  assign sel   = {bus.c1, bus.c0};
  assign bus.m = x[sel];

  mux_scan_ctrl #(.DWELL_W(DWELL_W), .FCNT_W(FCNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]        frame;
    logic [FCNT_W-1:0] fcnt;
    int                cyc;
  } exp_t;

  typedef struct {
    logic [3:0] pat;
    int         dwell;
  } vec_t;

  exp_t              sb[$];
  logic [FCNT_W-1:0] exp_fcnt = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int effDwell(input int dw);
    return (dw < MIN_D) ? MIN_D : dw;
  endfunction

  // Every frame_valid must match the oldest expected frame, count and cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.frame_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid: got frame %0h at cycle %0d expected no frame_valid", bus.frame, cyc);
      end else begin
        e = sb.pop_front();
        check("sb_frame", 32'(bus.frame), 32'(e.frame));
        check("sb_fcnt", 32'(bus.frame_cnt), 32'(e.fcnt));
        check("sb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge; the next posedge is the start edge E0
  task automatic applyStimulus(input logic [3:0] pat, input int dw, input logic c, input int nframes);
    int eff;
    int base;
    eff       = effDwell(dw);
    base      = cyc + 1;
    x         = pat;
    bus.dwell = DWELL_W'(dw);
    bus.cont  = c;
    bus.start = 1'b1;
    for (int i = 0; i < nframes; i++) begin
      exp_fcnt = exp_fcnt + FCNT_W'(1);
      sb.push_back('{frame: pat, fcnt: exp_fcnt, cyc: base + i * (4 * eff + 1) + 4 * eff});
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] pat);
    check({name, "_frame"}, 32'(bus.frame), 32'(pat));
    check({name, "_busy"}, 32'(bus.busy), 32'(0));
    check({name, "_fcnt"}, 32'(bus.frame_cnt), 32'(exp_fcnt));
    check({name, "_pending"}, 32'(sb.size()), 32'(0));
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, 32'(bus.busy), 32'(0));
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int period;
    vecs[0] = '{pat: 4'b1001, dwell: 1};
    vecs[1] = '{pat: 4'b0010, dwell: 4};
    vecs[2] = '{pat: 4'b0110, dwell: 0};
    vecs[3] = '{pat: 4'b1111, dwell: 2};
    vecs[4] = '{pat: 4'b0000, dwell: 3};
    vecs[5] = '{pat: 4'b0101, dwell: 255};

    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.cont  = 1'b0;
    bus.dwell = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_sel", 32'(sel), 32'(0));
    check("rst_frame", 32'(bus.frame), 32'(0));
    check("rst_valid", 32'(bus.frame_valid), 32'(0));
    check("rst_fcnt", 32'(bus.frame_cnt), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Select stepping, one dwell per channel, then DONE with selects parked at 00
    applyStimulus(4'b1001, 1, 1'b0, 1);
    for (int i = 0; i < 4 * MIN_D; i++) begin
      check("step_sel", 32'(sel), 32'(i / MIN_D));
      check("step_busy", 32'(bus.busy), 32'(1));
      @(negedge clk);
    end
    check("done_sel", 32'(sel), 32'(0));
    check("done_valid", 32'(bus.frame_valid), 32'(1));
    waitIdle("step", 20);
    checkOutput("step", 4'b1001);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].pat, vecs[v].dwell, 1'b0, 1);
      waitIdle("vec", 4 * 256 + 20);
      checkOutput("vec", vecs[v].pat);
    end

    // Continuous mode through a frame-counter wrap, then abort mid-frame
    period = 4 * effDwell(2) + 1;
    applyStimulus(4'b0110, 2, 1'b1, 300);
    n = 0;
    while (sb.size() > 0 && n < 300 * period + 50) begin
      @(negedge clk);
      n++;
    end
    check("cont_drain", 32'(sb.size()), 32'(0));
    repeat (3) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_busy", 32'(bus.busy), 32'(0));
    check("stop_sel", 32'(sel), 32'(0));
    check("stop_valid", 32'(bus.frame_valid), 32'(0));
    repeat (2 * period) @(negedge clk);
    checkOutput("stop", 4'b0110);
    bus.cont = 1'b0;

    // start and stop together in IDLE leaves the block idle
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("startstop_busy", 32'(bus.busy), 32'(0));
    repeat (3) @(negedge clk);
    check("startstop_busy2", 32'(bus.busy), 32'(0));

    // start, dwell and cont changes while busy have no effect
    applyStimulus(4'b1100, 2, 1'b0, 1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.dwell = DWELL_W'(7);
    bus.cont  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitIdle("busy_start", 100);
    bus.cont = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("busy_start", 4'b1100);

    // Asynchronous reset during channel 2 wipes everything without a frame
    applyStimulus(4'b1011, 2, 1'b0, 0);
    n = 0;
    while (sel !== 2'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_ch2", 32'(sel), 32'(2));
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'(0));
    check("arst_sel", 32'(sel), 32'(0));
    check("arst_frame", 32'(bus.frame), 32'(0));
    check("arst_valid", 32'(bus.frame_valid), 32'(0));
    check("arst_fcnt", 32'(bus.frame_cnt), 32'(0));
    exp_fcnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(4'b1001, 1, 1'b0, 1);
    waitIdle("post_rst", 40);
    checkOutput("post_rst", 4'b1001);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer sitting directly upstream of the 4:1 mux circuit (inputs x0..x3, selects c0/c1, output m).
- Drives c1/c0 to step through channels 0..3 and holds each channel for a programmable dwell.
- Samples m at the end of each dwell and packs the four results into a 4-bit frame, reported with a one-cycle valid pulse.
- Supports one-shot and continuous scanning, plus abort.

Parameters:
- DWELL_W, 8, width of the dwell input and the dwell counter.
- FCNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan. Sampled only in IDLE.
- stop  input  1  abort the scan. Highest priority after reset.
- cont  input  1  continuous mode. Latched on start.
- dwell  input  DWELL_W  cycles per channel. Latched on start; 0 is treated as 1.
- m  input  1  mux output being scanned.
- c0  output  1  mux select LSB.
- c1  output  1  mux select MSB.
- busy  output  1  high while a scan is in progress.
- frame  output  4  last completed frame; bit k = m sampled with select k.
- frame_valid  output  1  one-cycle pulse when frame updates.
- frame_cnt  output  FCNT_W  number of completed frames, wraps modulo 2^FCNT_W.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE, c1c0=00, busy=0, frame=0, frame_valid=0, frame_cnt=0. Internal dwell/cont latches and shadow frame are cleared.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 && stop=0 at edge E0 → SCAN.
  - At that edge: ch=0, cnt=0, latch D=max(dwell,1), latch cont, busy=1.
- SCAN:
  - c1c0 = ch. cnt increments each edge.
  - On the edge where cnt==D-1: shadow[ch] <= m, cnt <= 0.
  - If ch<3 at that edge: ch <= ch+1.
  - If ch==3 at that edge: go to DONE.
- DONE (one cycle):
  - frame <= shadow, including bit 3 captured on entry; frame is visible together with frame_valid=1.
  - frame_cnt increments.
  - cont=1: next edge → SCAN, with ch=0, cnt=0, c1c0=00, and D/cont kept from the original latch.
  - cont=0: next edge → IDLE, busy=0.
- Latency: frame_valid is high in the cycle after edge E0+4·D. For D=1, frame_valid is high after E4.
- Continuous period is 4·D+1 cycles per frame.
- c1c0 is 00 whenever the block is in IDLE or DONE.
- start while busy is ignored. dwell/cont changes while busy are ignored.
- stop=1 in SCAN or DONE: next edge → IDLE, busy=0, c1c0=00, no frame_valid. frame and frame_cnt hold.
- stop and start in the same IDLE cycle: stop wins and the block stays in IDLE.
- Reset mid-scan: immediate return to reset values; no partial frame is emitted.
- frame_cnt wraps from 2^FCNT_W-1 to 0 with no flag.

Optional Feature:
- Macro MUX_SCAN_SYNC_EN.
- Defined:
  - m passes through a 2-flop synchroniser before sampling.
  - Effective dwell is max(dwell,3), so each sample reflects the current select after 2 cycles of pipeline delay.
  - Latency becomes 4·max(dwell,3) edges.
- Undefined:
  - m is sampled directly.
  - Effective dwell is max(dwell,1).

Decomposition:
- Package mux_scan_pkg contains:
  - state enum (IDLE, SCAN, DONE)
  - NUM_CH=4
  - SYNC_STAGES=2
  - MIN_DWELL_SYNC=3
- One sub-module, mux_scan_sync: 2-flop synchroniser with async active-low reset to 0. Instantiated only under MUX_SCAN_SYNC_EN.

Test Plan:
1. Mux inputs x0..x3 = 1,0,0,1; dwell=1, cont=0, start pulse → c1c0 steps 00,01,10,11 for one cycle each; frame=4'b1001; frame_valid pulses once; frame_cnt=1; busy drops.
2. dwell=4, x1 driven to 1, others 0, cont=0 → each select held 4 cycles; frame_valid exactly 16 edges after start edge; frame=4'b0010.
3. dwell=0 → behaves exactly as dwell=1.
4. cont=1, dwell=2, run 300 frames → frame_valid every 9 cycles; frame_cnt wraps 255→0; stop mid-frame → IDLE next edge, no further frame_valid, frame holds.
5. start and stop asserted together in IDLE → no busy. start pulsed while busy → ignored, period unchanged.
6. rst_n low during ch2 of a scan → all outputs reset immediately. With MUX_SCAN_SYNC_EN and dwell=1 → frame_valid after 12 edges with the correct frame.
